// File: rtl/csr_counter_bank.sv
// RISC-V counter/CSR bank: cycle, prescaled time, instret and N_HPM event counters
// with machine-mode writes, count inhibit, sticky overflow flags and a registered read port.
module csr_counter_bank #(
  parameter int CNT_W    = 64,
  parameter int N_HPM    = 4,
  parameter int TIME_DIV = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                retire,
  input  logic [((N_HPM > 0) ? N_HPM : 1)-1:0] hpm_event,
  input  logic [11:0]                         csr_addr,
  input  logic                                csr_rd_en,
  input  logic                                csr_wr_en,
  input  logic [31:0]                         csr_wdata,
  output logic [31:0]                         csr_rdata,
  output logic                                csr_rvalid,
  output logic                                csr_err,
  output logic [N_HPM+2:0]                    ovf
);

  localparam int NCNT = 3 + N_HPM;
  localparam int PW   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TIME_DIV - 1);
  // Bit 1 (time) can never be inhibited.
  localparam logic [NCNT-1:0] INH_MASK  = ~(NCNT'(2));
  localparam int IDX_CYCLE = 0;
  localparam int IDX_TIME  = 1;
  localparam int IDX_INST  = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RO_LO,
    SEL_RO_HI,
    SEL_RW_LO,
    SEL_RW_HI,
    SEL_INHIBIT,
    SEL_OVF
  } sel_e;

  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  inh_q, inh_d;
  logic [NCNT-1:0]  ovf_q, ovf_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;

  sel_e        sel;
  logic [4:0]  idx;
  logic        idx_hit;
  logic        wr_ok;
  logic        access_err;
  logic [63:0] sel64;
  logic [63:0] wr_merge;
  logic [31:0] rd_val;
  logic        presc_wrap;
  logic [NCNT-1:0] inc_ev;
  logic [NCNT-1:0] wrapped;

  // Address decode and read mux.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sel      = SEL_NONE;
    idx      = csr_addr[4:0];
    idx_hit  = (csr_addr[6:5] == 2'b00) && (int'(idx) < NCNT);
    sel64    = '0;
    rd_val   = '0;
    wr_merge = '0;

    unique case (csr_addr[11:8])
      4'hC: if (idx_hit) sel = csr_addr[7] ? SEL_RO_HI : SEL_RO_LO;
      4'hB: if (idx_hit && idx != 5'(IDX_TIME)) sel = csr_addr[7] ? SEL_RW_HI : SEL_RW_LO;
      4'h3: if (csr_addr[7:0] == 8'h20) sel = SEL_INHIBIT;
      4'h7: if (csr_addr[7:0] == 8'hC0) sel = SEL_OVF;
      default: sel = SEL_NONE;
    endcase

    for (int k = 0; k < NCNT; k++) begin
      if (5'(k) == idx) sel64 = 64'(cnt_q[k]);
    end

    // Zero-extending to 64 bits keeps the half-select legal for any CNT_W, including 32.
    unique case (sel)
      SEL_RO_LO, SEL_RW_LO: rd_val = sel64[31:0];
      SEL_RO_HI, SEL_RW_HI: rd_val = sel64[63:32];
      SEL_INHIBIT:          rd_val = 32'(inh_q);
      SEL_OVF:              rd_val = 32'(ovf_q);
      default:              rd_val = '0;
    endcase

    wr_merge = sel64;
    if (sel == SEL_RW_HI) wr_merge[63:32] = csr_wdata;
    else                  wr_merge[31:0]  = csr_wdata;

    wr_ok      = csr_wr_en && (sel inside {SEL_RW_LO, SEL_RW_HI, SEL_INHIBIT, SEL_OVF});
    access_err = ((csr_rd_en || csr_wr_en) && (sel == SEL_NONE)) ||
                 (csr_wr_en && (sel inside {SEL_RO_LO, SEL_RO_HI}));
  end

  // Counter, prescaler, inhibit and overflow next state.
  always_comb begin
    presc_wrap = (presc_q == PRESC_MAX);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;

    inc_ev            = '0;
    inc_ev[IDX_CYCLE] = 1'b1;
    inc_ev[IDX_TIME]  = presc_wrap;
    inc_ev[IDX_INST]  = retire;
    for (int i = 0; i < N_HPM; i++) inc_ev[3+i] = hpm_event[i];

    wrapped = '0;
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (wr_ok && (sel inside {SEL_RW_LO, SEL_RW_HI}) && (5'(k) == idx)) begin
        cnt_d[k] = wr_merge[CNT_W-1:0];
      end else if (inc_ev[k] && !inh_q[k]) begin
        cnt_d[k]   = cnt_q[k] + 1'b1;
        wrapped[k] = &cnt_q[k];
      end
    end

    inh_d = inh_q;
    if (wr_ok && sel == SEL_INHIBIT) inh_d = csr_wdata[NCNT-1:0] & INH_MASK;

    // A wrap on the same edge as a write-1-to-clear leaves the flag set.
    ovf_d = ovf_q;
    if (wr_ok && sel == SEL_OVF) ovf_d = ovf_q & ~csr_wdata[NCNT-1:0];
    ovf_d = ovf_d | wrapped;

    rvalid_d = csr_rd_en;
    err_d    = access_err;
    rdata_d  = csr_rd_en ? rd_val : rdata_q;
  end

  // NOTE: the counters are individual flops rather than a RAM, so resetting the whole array is cheap and required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      inh_q    <= '0;
      ovf_q    <= '0;
      presc_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state.
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
      inh_q    <= inh_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign csr_rdata  = rdata_q;
  assign csr_rvalid = rvalid_q;
  assign csr_err    = err_q;
  assign ovf        = ovf_q;

endmodule
